// File: rtl/dbus_pkg.sv
// Shared encodings for the data-bus controller: access sizes, FSM states, log2 helper.
// No logic of its own; imported by dbus_ctrl and store_buf.
// No handshake of its own.
package dbus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/store_buf.sv
// Posted-store FIFO of {addr,size,data} with a per-entry word-address match against a probe.
// Push and pop take effect on the next edge; head and match outputs are combinational.
// No internal backpressure: the owner must not push when full unless it pops in the same cycle.
module store_buf
    import dbus_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_x,
    input  logic             i_push,
    input  logic [AW-1:0]    i_addr,
    input  logic [1:0]       i_size,
    input  logic [DW-1:0]    i_data,
    input  logic             i_pop,
    input  logic [AW-3:0]    i_probe_waddr,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW-1:0]    o_head_addr,
    output logic [1:0]       o_head_size,
    output logic [DW-1:0]    o_head_data,
    output logic [DEPTH-1:0] o_match
);

    localparam int            PW      = clog2(DEPTH);
    localparam logic [PW:0]   PTR_ONE = (PW + 1)'(1);

    logic [AW-1:0]    r_addr [DEPTH];
    logic [1:0]       r_size [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW:0]      r_wptr;
    logic [PW:0]      r_rptr;

    logic [PW-1:0]    w_widx;
    logic [PW-1:0]    w_ridx;
    logic [DEPTH-1:0] w_vld_nxt;

    assign w_widx      = r_wptr[PW-1:0];
    assign w_ridx      = r_rptr[PW-1:0];
    assign o_empty     = (r_wptr == r_rptr);
    assign o_full      = (r_wptr[PW] != r_rptr[PW]) && (w_widx == w_ridx);
    assign o_head_addr = r_addr[w_ridx];
    assign o_head_size = r_size[w_ridx];
    assign o_head_data = r_data[w_ridx];

    // Clear before set so a push into the slot being popped (full case) stays valid.
    always_comb begin
        w_vld_nxt = r_vld;
        if (i_pop) begin
            w_vld_nxt[w_ridx] = 1'b0;
        end
        if (i_push) begin
            w_vld_nxt[w_widx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_vld  <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_vld <= w_vld_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[w_widx] <= i_addr;
            r_size[w_widx] <= i_size;
            r_data[w_widx] <= i_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_match[i] = r_vld[i] && (r_addr[i][AW-1:2] == i_probe_waddr);
        end
    end

endmodule

// File: rtl/dbus_ctrl.sv
// M-stage data-bus controller: loads go straight to the bus, stores are posted, fence drains.
// Zero-wait load costs one stall cycle; stores are accepted the same cycle unless the buffer is full.
// Stalls the pipeline on loads, full buffer (without pop) and fence; converts bus timeouts to m_fault.
module dbus_ctrl
    import dbus_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int WB_DEPTH = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          reset_x,
    input  logic          m_req,
    input  logic          m_write,
    input  logic [1:0]    m_size,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_wdata,
    input  logic          m_fence,
    output logic [DW-1:0] m_rdata,
    output logic          m_stall,
    output logic          m_fault,
    output logic [AW-1:0] m_fault_addr,
    output logic          MREQ,
    output logic          WRITE,
    output logic [1:0]    SIZE,
    output logic [AW-1:0] DAD,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          ACKD_n
);

    localparam int             TCW       = (TIMEOUT < 2) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [TCW-1:0] TMO_LIMIT = TCW'(TIMEOUT);
    localparam logic [TCW-1:0] TCNT_ONE  = TCW'(1);

    state_t        r_state;
    state_t        w_nxt_state;
    logic          r_mreq;
    logic          r_write;
    logic [1:0]    r_size;
    logic [AW-1:0] r_dad;
    logic [DW-1:0] r_wdata;
    logic          r_fault;
    logic [AW-1:0] r_fault_addr;
    logic [TCW-1:0] r_tcnt;

    logic                w_full;
    logic                w_empty;
    logic [AW-1:0]       w_head_addr;
    logic [1:0]          w_head_size;
    logic [DW-1:0]       w_head_data;
    logic [WB_DEPTH-1:0] w_match;
    logic                w_match_any;
    logic                w_ack;
    logic                w_tmo;
    logic                w_end;
    logic                w_pop;
    logic                w_push;
    logic                w_is_load;
    logic                w_load_rd;
    logic                w_load_wr;

    store_buf #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (WB_DEPTH)
    ) u_store_buf (
        .clk           (clk),
        .reset_x       (reset_x),
        .i_push        (w_push),
        .i_addr        (m_addr),
        .i_size        (m_size),
        .i_data        (m_wdata),
        .i_pop         (w_pop),
        .i_probe_waddr (m_addr[AW-1:2]),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_head_addr   (w_head_addr),
        .o_head_size   (w_head_size),
        .o_head_data   (w_head_data),
        .o_match       (w_match)
    );

    assign w_match_any = |w_match;
    assign w_is_load   = m_req & ~m_write;
    assign w_ack       = ~ACKD_n;
    assign w_tmo       = (TIMEOUT != 0) && (r_state != ST_IDLE) && ACKD_n && (r_tcnt == TMO_LIMIT);
    assign w_end       = (r_state != ST_IDLE) && (w_ack || w_tmo);
    // A timed-out store is still popped: it is lost rather than retried forever.
    assign w_pop       = (r_state == ST_WR) && w_end;

    assign m_stall = (w_is_load & ~((r_state == ST_RD) & (w_ack | w_tmo)))
                   | (m_req & m_write & w_full & ~w_pop)
                   | (m_fence & ~(w_empty & (r_state == ST_IDLE)));
    assign w_push  = m_req & m_write & ~m_stall;
    assign m_rdata = ((r_state == ST_RD) && w_ack) ? bus_rdata : '0;

    assign MREQ         = r_mreq;
    assign WRITE        = r_write;
    assign SIZE         = r_size;
    assign DAD          = r_dad;
    assign bus_wdata    = r_wdata;
    assign m_fault      = r_fault;
    assign m_fault_addr = r_fault_addr;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Loads beat buffered stores unless they alias a buffered word.
    always_comb begin
        w_nxt_state = r_state;
        w_load_rd   = 1'b0;
        w_load_wr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_load && !w_match_any) begin
                    w_nxt_state = ST_RD;
                    w_load_rd   = 1'b1;
                end else if (!w_empty) begin
                    w_nxt_state = ST_WR;
                    w_load_wr   = 1'b1;
                end
            end
            ST_RD, ST_WR: begin
                if (w_end) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_mreq  <= 1'b0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_dad   <= '0;
            r_wdata <= '0;
        end else if (w_load_rd) begin
            r_mreq  <= 1'b1;
            r_write <= 1'b0;
            r_size  <= m_size;
            r_dad   <= m_addr;
        end else if (w_load_wr) begin
            r_mreq  <= 1'b1;
            r_write <= 1'b1;
            r_size  <= w_head_size;
            r_dad   <= w_head_addr;
            r_wdata <= w_head_data;
        end else if (w_end) begin
            r_mreq  <= 1'b0;
            r_write <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_tcnt       <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            r_fault <= w_tmo;
            if (w_tmo) begin
                r_fault_addr <= r_dad;
            end
            if (w_load_rd || w_load_wr) begin
                r_tcnt <= '0;
            end else if ((TIMEOUT != 0) && (r_state != ST_IDLE) && ACKD_n) begin
                r_tcnt <= r_tcnt + TCNT_ONE;
            end
        end
    end

endmodule
